// File: rtl/restoring_divider_4bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_pkg
// Brief    : Shared widths, iteration count and FSM state type for the divider.
// Revision : 1.0
// ============================================================================
package divider_pkg;

  localparam int DIV_W    = 4;
  localparam int DIV_ITER = 4;

  localparam logic [1:0] LAST_ITER = 2'(DIV_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/restoring_divider_4bit_if.sv
`default_nettype none
// ============================================================================
// Module   : restoring_divider_4bit_if
// Brief    : Request/result bundle between a requester and the divider.
// Revision : 1.0
// ============================================================================
interface restoring_divider_4bit_if;
  import divider_pkg::*;

  logic             start;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/fourbit_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : fourbit_subtractor
// Brief    : 4-bit ripple-borrow subtractor, diff = X - Y, borrow set when X < Y.
// Revision : 1.0
// ============================================================================
module fourbit_subtractor (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic [3:0] diff,
  output logic       borrow
);

  logic brw;

  always_comb begin
    diff = 4'd0;
    brw  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      diff[i] = X[i] ^ Y[i] ^ brw;
      brw     = (~X[i] & Y[i]) | (~(X[i] ^ Y[i]) & brw);
    end
    borrow = brw;
  end

endmodule
`default_nettype wire

// File: rtl/restoring_divider_4bit.sv
`default_nettype none
// ============================================================================
// Module   : restoring_divider_4bit
// Brief    : Sequential 4-bit unsigned restoring divider, one trial subtraction
//            per clock, single-cycle done pulse.
// Revision : 1.0
// ============================================================================
module restoring_divider_4bit
  import divider_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  restoring_divider_4bit_if.slave  bus
);

  div_state_t       state_q, state_d;
  logic [DIV_W-1:0] q_q, q_d;
  logic [DIV_W-1:0] r_q, r_d;
  logic [DIV_W-1:0] d_q, d_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIV_W-1:0] trial;
  logic [DIV_W-1:0] sub_diff;
  logic             sub_borrow;

  // R stays below 2^k after k iterations, so the shifted trial never overflows.
  assign trial = {r_q[DIV_W-2:0], q_q[DIV_W-1]};

  fourbit_subtractor u_sub (
    .X      (trial),
    .Y      (d_q),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          d_d    = bus.divisor;
          cnt_d  = 2'd0;
          busy_d = 1'b1;
          if (bus.divisor == '0) begin
            q_d     = '1;
            r_d     = bus.dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = bus.dividend;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d   = sub_borrow ? trial : sub_diff;
        q_d   = {q_q[DIV_W-2:0], ~sub_borrow};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_ITER) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= 2'd0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire
